sobel_frame_capture: RTL

- Receiving end of the filter pixel stream: takes the raster-order output pixels of the sobel filter and writes them into an internal WIDTH x HEIGHT frame buffer.
- Discards the filter's warm-up pixels, tracks row and column, and optionally zeroes border positions.
- Signals frame completion; a host-side read port then reads the frame back.
- Sits directly after the sobel filter in the image pipeline, as the counterpart of the pixel source that drives the filter.

---
 rtl/image_pkg.sv | 18 +
 rtl/sobel_frame_capture_if.sv | 30 +++
 rtl/frame_ram.sv | 38 +++
 rtl/sobel_frame_capture.sv | 136 +++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared image-pipeline definitions: default frame geometry, pixel type and
// the capture state encoding.
package image_pkg;

    localparam int SIZE_WORD = 8;
    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 8;

    typedef logic [SIZE_WORD-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE,
        DONE
    } cap_state_t;

endpackage

// File: rtl/sobel_frame_capture_if.sv
// Stream, status and host read-back signals of the frame capture block.
interface sobel_frame_capture_if #(
    parameter int SIZE_WORD = image_pkg::SIZE_WORD,
    parameter int WIDTH     = image_pkg::WIDTH,
    parameter int HEIGHT    = image_pkg::HEIGHT
);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);

    logic                 start;
    logic                 inValid;
    logic [SIZE_WORD-1:0] inputPixel;
    logic                 busy;
    logic                 frameDone;
    logic                 rdEn;
    logic [AW-1:0]        rdAddr;
    logic [SIZE_WORD-1:0] rdData;
    logic [CW-1:0]        capCount;

    modport master (
        output start, inValid, inputPixel, rdEn, rdAddr,
        input  busy, frameDone, rdData, capCount
    );

    modport slave (
        input  start, inValid, inputPixel, rdEn, rdAddr,
        output busy, frameDone, rdData, capCount
    );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, registered read that
// returns the pre-write contents on a same-address collision.
module frame_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Addresses past the frame (non power-of-two geometries) read as zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sobel_frame_capture.sv
// Captures the sobel filter's raster output into a WIDTH x HEIGHT buffer,
// dropping the pipeline warm-up pixels and optionally blanking the border.
module sobel_frame_capture #(
    parameter int SIZE_WORD   = image_pkg::SIZE_WORD,
    parameter int WIDTH       = image_pkg::WIDTH,
    parameter int HEIGHT      = image_pkg::HEIGHT,
    parameter int SKIP        = WIDTH + 2,
    parameter int ZERO_BORDER = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    sobel_frame_capture_if.slave bus
);
    import image_pkg::*;

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CLW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW    = $clog2(SKIP + 2);

    // State literals are scoped because the SKIP parameter hides the enum item.
    cap_state_t           r_state;
    cap_state_t           w_next;
    logic [SW-1:0]        r_skip;
    logic [RW-1:0]        r_row;
    logic [CLW-1:0]       r_col;
    logic [AW-1:0]        r_addr;
    logic [CW-1:0]        r_count;
    logic                 w_start_ok;
    logic                 w_skip_px;
    logic                 w_cap_px;
    logic                 w_last_px;
    logic                 w_border;
    logic [SIZE_WORD-1:0] w_wr_data;

    assign w_start_ok = (r_state == image_pkg::IDLE) && bus.start;
    assign w_skip_px  = (r_state == image_pkg::SKIP) && bus.inValid;
    assign w_cap_px   = (r_state == image_pkg::CAPTURE) && bus.inValid;
    assign w_last_px  = w_cap_px && (r_row == RW'(HEIGHT - 1)) && (r_col == CLW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= image_pkg::IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            image_pkg::IDLE: begin
                if (bus.start) begin
                    w_next = (SKIP > 0) ? image_pkg::SKIP : image_pkg::CAPTURE;
                end
            end
            image_pkg::SKIP: begin
                if (bus.inValid && (r_skip == SW'(1))) begin
                    w_next = image_pkg::CAPTURE;
                end
            end
            image_pkg::CAPTURE: begin
                if (w_last_px) begin
                    w_next = image_pkg::DONE;
                end
            end
            image_pkg::DONE: w_next = image_pkg::IDLE;
            default:         w_next = image_pkg::IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.frameDone = 1'b0;
        case (r_state)
            image_pkg::SKIP, image_pkg::CAPTURE: bus.busy = 1'b1;
            image_pkg::DONE:                     bus.frameDone = 1'b1;
            default: ;
        endcase
    end

    // Linear write address runs alongside row/col so no multiplier is needed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_skip  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else if (w_start_ok) begin
            r_skip  <= SW'(SKIP);
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            if (w_skip_px) begin
                r_skip <= r_skip - 1'b1;
            end
            if (w_cap_px) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
                if (r_col == CLW'(WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign w_border  = (r_row == '0) || (r_row == RW'(HEIGHT - 1)) ||
                       (r_col == '0) || (r_col == CLW'(WIDTH - 1));
    assign w_wr_data = ((ZERO_BORDER != 0) && w_border) ? '0 : bus.inputPixel;

    frame_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (SIZE_WORD),
        .AW     (AW)
    ) u_frame_ram (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_we    (w_cap_px),
        .i_waddr (r_addr),
        .i_wdata (w_wr_data),
        .i_re    (bus.rdEn),
        .i_raddr (bus.rdAddr),
        .o_rdata (bus.rdData)
    );

    assign bus.capCount = r_count;

endmodule
